// File: rtl/mem_access_unit.sv
// Load/store sequencer for the data port of the unified byte-addressable memory.
// Misaligned halfword/word accesses are split into byte accesses and reassembled.
module mem_access_unit #(
    parameter int ADDR_W           = 10,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_func3,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q;
    logic [1:0]          cnt_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          func3_q;
    logic [31:0]         wdata_q;
    logic                write_q;
    logic [31:0]         buf_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic [31:0]         resp_rdata_q;
    logic                resp_err_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [2:0]          mem_func3_q;
    logic [31:0]         mem_wdata_q;

    logic                illegal_d;
    logic                misal_d;
    logic [1:0]          last_idx_d;
    logic [1:0]          next_cnt_d;
    logic [31:0]         asm_d;
    logic [31:0]         ext_d;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Decode of the latched request and byte reassembly of split loads.
    always_comb begin
        illegal_d  = (func3_q == 3'b011) || (func3_q[2:1] == 2'b11) || (write_q && func3_q[2]);
        misal_d    = ((func3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((func3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        last_idx_d = (func3_q[1:0] == 2'b10) ? 2'd3 : 2'd1;
        next_cnt_d = cnt_q + 2'd1;
        asm_d      = buf_q;
        case (cnt_q)
            2'd0:    asm_d[7:0]   = mem_rdata[7:0];
            2'd1:    asm_d[15:8]  = mem_rdata[7:0];
            2'd2:    asm_d[23:16] = mem_rdata[7:0];
            2'd3:    asm_d[31:24] = mem_rdata[7:0];
            default: asm_d        = buf_q;
        endcase
        if (func3_q[1:0] == 2'b01) begin
            ext_d = {(func3_q[2] ? 16'h0000 : {16{asm_d[15]}}), asm_d[15:0]};
        end else begin
            ext_d = asm_d;
        end
    end

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            func3_q      <= 3'b000;
            wdata_q      <= 32'h0000_0000;
            write_q      <= 1'b0;
            buf_q        <= 32'h0000_0000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_func3_q  <= 3'b000;
            mem_wdata_q  <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0000_0000;
                    resp_err_q   <= 1'b0;
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        func3_q     <= req_func3;
                        wdata_q     <= req_wdata;
                        write_q     <= req_write;
                        cnt_q       <= 2'd0;
                        busy_q      <= 1'b0;
                        buf_q       <= 32'h0000_0000;
                        req_ready_q <= 1'b0;
                        state_q     <= S_ACCESS;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (!busy_q) begin
                        // First cycle only decodes; the first memory beat is launched from here.
                        if (illegal_d || (misal_d && !SPLIT_MISALIGNED)) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                            state_q      <= S_DONE;
                        end else begin
                            busy_q      <= 1'b1;
                            mem_read_q  <= !write_q;
                            mem_write_q <= write_q;
                            mem_addr_q  <= addr_q;
                            if (misal_d) begin
                                mem_func3_q <= write_q ? 3'b000 : 3'b100;
                                mem_wdata_q <= write_q ? {24'h00_0000, byte_sel(wdata_q, 2'd0)} : 32'h0000_0000;
                            end else begin
                                mem_func3_q <= func3_q;
                                mem_wdata_q <= wdata_q;
                            end
                        end
                    end else if (!misal_d || (cnt_q == last_idx_d)) begin
                        if (write_q) begin
                            resp_rdata_q <= 32'h0000_0000;
                        end else if (misal_d) begin
                            resp_rdata_q <= ext_d;
                        end else begin
                            resp_rdata_q <= mem_rdata;
                        end
                        buf_q        <= write_q ? buf_q : asm_d;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_func3_q  <= 3'b000;
                        mem_wdata_q  <= 32'h0000_0000;
                        state_q      <= S_DONE;
                    end else begin
                        buf_q       <= asm_d;
                        cnt_q       <= next_cnt_d;
                        mem_addr_q  <= addr_q + ADDR_W'(next_cnt_d);
                        mem_wdata_q <= write_q ? {24'h00_0000, byte_sel(wdata_q, next_cnt_d)} : 32'h0000_0000;
                    end
                end
                S_DONE: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0000_0000;
                    resp_err_q   <= 1'b0;
                    busy_q       <= 1'b0;
                    cnt_q        <= 2'd0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    cnt_q        <= 2'd0;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0000_0000;
                    resp_err_q   <= 1'b0;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_func3  = mem_func3_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a byte-array memory, a request-level
// reference model and a bus-trace scoreboard; a second instance covers rejection of misalignment.
module tb_mem_access_unit;

    localparam int AW = 10;

    typedef struct packed {
        logic [9:0]  a;
        logic [2:0]  f3;
        logic        wr;
        logic [31:0] wd;
    } bus_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]    req_func3 = 3'b000;
    logic [AW-1:0] req_addr  = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0]   resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_func3;

    logic          n_req_valid = 1'b0, n_req_write = 1'b0;
    logic [2:0]    n_req_func3 = 3'b000;
    logic [AW-1:0] n_req_addr  = '0;
    logic [31:0]   n_req_wdata = 32'h0;
    logic          n_req_ready, n_resp_valid, n_resp_err, n_mem_read, n_mem_write;
    logic [31:0]   n_resp_rdata, n_mem_wdata, n_mem_rdata;
    logic [AW-1:0] n_mem_addr;
    logic [2:0]    n_mem_func3;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];
    logic       mem_init = 1'b1;
    logic       ld_en = 1'b0;
    logic [9:0] ld_addr = 10'h0;
    logic [7:0] ld_data = 8'h0;

    int   n_checks = 0;
    int   n_pass   = 0;
    bus_t exp_q[$];
    bus_t obs_q[$];

    mem_access_unit #(.ADDR_W(AW), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_func3(mem_func3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.ADDR_W(AW), .SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(n_req_valid), .req_write(n_req_write), .req_func3(n_req_func3),
        .req_addr(n_req_addr), .req_wdata(n_req_wdata), .req_ready(n_req_ready),
        .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
        .mem_read(n_mem_read), .mem_write(n_mem_write), .mem_addr(n_mem_addr),
        .mem_func3(n_mem_func3), .mem_wdata(n_mem_wdata), .mem_rdata(n_mem_rdata)
    );

    function automatic logic [7:0] init_byte(input int k);
        return 8'((k * 37 + 11) ^ (k >> 2));
    endfunction

    // Memory read port: returns the access already sign/zero-extended per func3.
    function automatic logic [31:0] mem_rd(input logic [9:0] a, input logic [2:0] f3);
        logic [9:0]  a1, a2, a3;
        logic [31:0] w;
        a1 = a + 10'd1;
        a2 = a + 10'd2;
        a3 = a + 10'd3;
        w  = {mem[a3], mem[a2], mem[a1], mem[a]};
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            2'b01:   return f3[2] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign mem_rdata   = mem_read   ? mem_rd(mem_addr, mem_func3)     : 32'h0;
    assign n_mem_rdata = n_mem_read ? mem_rd(n_mem_addr, n_mem_func3) : 32'h0;

    // Byte-addressable memory with wrap-around, plus bench init/poke paths.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 1024; k++) mem[k] <= init_byte(k);
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_write) begin
            for (int k = 0; k < 4; k++)
                if (k < ((mem_func3[1:0] == 2'b00) ? 1 : (mem_func3[1:0] == 2'b01) ? 2 : 4))
                    mem[10'(mem_addr + 10'(k))] <= mem_wdata[8*k +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        ld_addr = a; ld_data = d; ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
        ref_mem[a] = d;
        @(negedge clk);
    endtask

    // Request-level reference: expected bus beats, response and memory effect.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [9:0] addr,
                         input logic [31:0] wd, input bit split,
                         output logic [31:0] rd, output logic err, output int lat);
        int          n;
        bit          illegal, mis;
        logic [9:0]  ai;
        logic [31:0] v;
        exp_q.delete();
        n       = 1 << f3[1:0];
        illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (wr && f3[2]);
        mis     = (n > 1) && ((int'(addr) % n) != 0);
        rd = 32'h0; err = 1'b0;
        if (illegal || (mis && !split)) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        if (!mis) begin
            exp_q.push_back('{a: addr, f3: f3, wr: wr, wd: wd});
            lat = 2;
        end else begin
            for (int i = 0; i < n; i++)
                exp_q.push_back('{a: addr + 10'(i), f3: (wr ? 3'b000 : 3'b100), wr: wr,
                                  wd: {24'h0, wd[8*i +: 8]}});
            lat = n + 1;
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            ai = addr + 10'(i);
            if (wr) ref_mem[ai] = wd[8*i +: 8];
            else    v[8*i +: 8] = ref_mem[ai];
        end
        if (!wr) begin
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
            rd = v;
        end
    endtask

    // Issue one request on the split instance and score it; returns at the response cycle.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [9:0] addr,
                          input logic [31:0] wd, input bit hold, input int exp_wait);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat, w, cyc, ready_hi;
        bit          got;
        req_write = wr; req_func3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (exp_wait >= 0) check("accept_wait", w, exp_wait);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        model(wr, f3, addr, wd, 1'b1, e_rd, e_err, e_lat);
        obs_q.delete();
        cyc = 0; ready_hi = 0; got = 1'b0;
        while (cyc < 12 && !got) begin
            @(negedge clk);
            cyc++;
            if (mem_read || mem_write) obs_q.push_back('{a: mem_addr, f3: mem_func3, wr: mem_write, wd: mem_wdata});
            if (req_ready) ready_hi++;
            if (resp_valid) got = 1'b1;
        end
        check("resp_seen", 32'(got), 32'd1);
        check("latency", cyc - 1, e_lat);
        check("resp_err", 32'(resp_err), 32'(e_err));
        check("resp_rdata", resp_rdata, e_rd);
        check("ready_low_busy", ready_hi, 0);
        check("beat_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check("beat_addr", 32'(obs_q[i].a), 32'(exp_q[i].a));
            check("beat_func3", 32'(obs_q[i].f3), 32'(exp_q[i].f3));
            check("beat_write", 32'(obs_q[i].wr), 32'(exp_q[i].wr));
            if (exp_q[i].wr) check("beat_wdata", obs_q[i].wd, exp_q[i].wd);
        end
    endtask

    // Load on the non-splitting instance; scored against the same model.
    task automatic n_req(input logic [2:0] f3, input logic [9:0] addr);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat, cyc, beats;
        bit          got;
        n_req_write = 1'b0; n_req_func3 = f3; n_req_addr = addr; n_req_valid = 1'b1;
        @(posedge clk); #1;
        n_req_valid = 1'b0;
        model(1'b0, f3, addr, 32'h0, 1'b0, e_rd, e_err, e_lat);
        cyc = 0; beats = 0; got = 1'b0;
        while (cyc < 12 && !got) begin
            @(negedge clk);
            cyc++;
            if (n_mem_read || n_mem_write) beats++;
            if (n_resp_valid) got = 1'b1;
        end
        check("ns_resp_seen", 32'(got), 32'd1);
        check("ns_latency", cyc - 1, e_lat);
        check("ns_err", 32'(n_resp_err), 32'(e_err));
        check("ns_rdata", n_resp_rdata, e_rd);
        check("ns_beats", beats, exp_q.size());
        @(negedge clk);
    endtask

    initial begin
        logic [9:0]  ra;
        logic [31:0] ignored_rd;
        logic        ignored_err;
        int          ignored_lat, found, stray, bad;
        for (int k = 0; k < 1024; k++) ref_mem[k] = init_byte(k);
        @(negedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        poke(10'h010, 8'h78); poke(10'h011, 8'h56); poke(10'h012, 8'h34); poke(10'h013, 8'h12);
        do_req(1'b0, 3'b010, 10'h010, 32'hDEAD_BEEF, 1'b0, 0);
        check("tp_lw", resp_rdata, 32'h1234_5678);

        n_req(3'b010, 10'h010);
        n_req(3'b010, 10'h002);
        n_req(3'b001, 10'h001);
        check("ns_lw_mis_err", 32'(n_resp_err), 32'd0);

        poke(10'h013, 8'hCD); poke(10'h014, 8'h9A);
        do_req(1'b0, 3'b001, 10'h013, 32'h0, 1'b0, 0);
        check("tp_lh", resp_rdata, 32'hFFFF_9ACD);
        do_req(1'b0, 3'b101, 10'h013, 32'h0, 1'b0, 1);
        check("tp_lhu", resp_rdata, 32'h0000_9ACD);

        do_req(1'b1, 3'b010, 10'h3FE, 32'h1122_3344, 1'b0, 1);
        do_req(1'b0, 3'b100, 10'h3FE, 32'h0, 1'b0, 1);
        check("tp_sw_b0", resp_rdata, 32'h44);
        do_req(1'b0, 3'b100, 10'h001, 32'h0, 1'b0, 1);
        check("tp_sw_b3", resp_rdata, 32'h11);
        do_req(1'b0, 3'b011, 10'h020, 32'h0, 1'b0, 1);
        check("tp_illegal_err", 32'(resp_err), 32'd1);

        // Reset in the middle of a split store: beats after the reset edge never happen.
        poke(10'h000, 8'hA0); poke(10'h001, 8'hA1);
        req_write = 1'b1; req_func3 = 3'b010; req_addr = 10'h3FE; req_wdata = 32'h5566_7788;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(negedge clk);
            if (mem_write && mem_addr == 10'h3FF) found = 1;
        end
        check("rst_mid_found", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_write", 32'(mem_write), 32'd0);
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_write || mem_read || resp_valid) stray++;
        end
        check("rst_mid_stray", stray, 0);
        ref_mem[10'h3FE] = 8'h88;
        ref_mem[10'h3FF] = 8'h77;
        do_req(1'b0, 3'b101, 10'h000, 32'h0, 1'b0, 0);
        check("rst_mid_untouched", resp_rdata, 32'h0000_A1A0);

        do_req(1'b0, 3'b010, 10'h010, 32'h0, 1'b1, 1);
        do_req(1'b0, 3'b000, 10'h3FF, 32'h0, 1'b1, 1);
        req_valid = 1'b0;

        for (int t = 0; t < 300; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? 10'(10'h3FC + 10'($urandom_range(0, 3)))
                                             : 10'($urandom_range(0, 1023));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                   1'($urandom_range(0, 1)), 1);
        end
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        bad = 0;
        for (int k = 0; k < 1024; k++) if (mem[k] !== ref_mem[k]) bad++;
        check("mem_image", bad, 0);
        model(1'b0, 3'b000, 10'h0, 32'h0, 1'b1, ignored_rd, ignored_err, ignored_lat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed 0x%08h expected 0x%08h", n_checks, 0);
        $fatal(1, "bench time limit");
    end

endmodule
